pmic_sampler: RTL and testbench

- Upstream capture stage for the PMod MIC path. Drives the board ADC's serial interface (active-low chip select, serial clock, serial data in) at a programmable sample interval.
- Each conversion frame is 16 bits, MSB first: 4 leading zero bits followed by 12 data bits.
- Every completed 12-bit sample is presented as a one-clock write strobe plus data, which feeds the sample FIFO's write port directly.

---
 rtl/pmic_sampler_if.sv | 27 ++
 rtl/pmic_sampler.sv | 148 ++++++++++++++
 tb/tb_pmic_sampler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmic_sampler_if.sv
// ADC serial pins plus the sample write port of pmic_sampler; master = sampler side.
interface pmic_sampler_if;
  logic        o_csn;
  logic        o_sck;
  logic        i_miso;
  logic        o_wr;
  logic [11:0] o_data;
  logic        o_overrun;

  modport master (
    output o_csn,
    output o_sck,
    input  i_miso,
    output o_wr,
    output o_data,
    output o_overrun
  );

  modport slave (
    input  o_csn,
    input  o_sck,
    output i_miso,
    input  o_wr,
    input  o_data,
    input  o_overrun
  );
endinterface

// File: rtl/pmic_sampler.sv
// PMod MIC ADC sampler: one 16-bit serial frame per interval, 12-bit sample strobed 33*CLKDIV+1 clocks after start.
// Frame occupies 34*CLKDIV+1 clocks; no backpressure, the downstream FIFO must take every o_wr.
module pmic_sampler #(
  parameter int CLKDIV = 4,
  parameter int LGINTV = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [LGINTV-1:0] i_interval,
  pmic_sampler_if.master    bus
);

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLKDIV - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [11:0]       shift_q, shift_d;
  logic [LGINTV-1:0] timer_q, timer_d;
  logic              csn_q, csn_d;
  logic              sck_q, sck_d;
  logic              wr_q, wr_d;
  logic              ovr_q, ovr_d;
  logic [11:0]       data_q, data_d;
  logic              miso_meta_q, miso_sync_q;

  logic phase_end;
  logic timer_zero;
  logic start;

  assign phase_end  = (cnt_q == HALF_LAST);
  assign timer_zero = (timer_q == '0);
  assign start      = (state_q == IDLE) && i_en && timer_zero;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    csn_d   = csn_q;
    sck_d   = sck_q;
    wr_d    = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        csn_d = 1'b1;
        sck_d = 1'b1;
        if (start) begin
          state_d = START;
          csn_d   = 1'b0;
        end
      end
      START: begin
        if (phase_end) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sck_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (phase_end) begin
          cnt_d = '0;
          // Only the low 12 bits survive; the 4 leading zeros fall off the top.
          if (!sck_q) begin
            shift_d = {shift_q[10:0], miso_sync_q};
            sck_d   = 1'b1;
          end else if (bit_q == 4'd15) begin
            state_d = STOP;
            bit_d   = '0;
            csn_d   = 1'b1;
            wr_d    = 1'b1;
            data_d  = shift_q;
          end else begin
            bit_d = bit_q + 4'd1;
            sck_d = 1'b0;
          end
        end
      end
      STOP: begin
        if (phase_end) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A zero timer outside IDLE means the next start is already late.
  always_comb begin
    timer_d = timer_q;
    ovr_d   = ovr_q;
    if (!i_en) begin
      timer_d = '0;
      ovr_d   = 1'b0;
    end else begin
      if (start) begin
        timer_d = (i_interval == '0) ? '0 : i_interval - LGINTV'(1);
      end else if (!timer_zero) begin
        timer_d = timer_q - LGINTV'(1);
      end
      if (timer_zero && (state_q != IDLE)) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      timer_q     <= '0;
      csn_q       <= 1'b1;
      sck_q       <= 1'b1;
      wr_q        <= 1'b0;
      ovr_q       <= 1'b0;
      data_q      <= '0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      timer_q     <= timer_d;
      csn_q       <= csn_d;
      sck_q       <= sck_d;
      wr_q        <= wr_d;
      ovr_q       <= ovr_d;
      data_q      <= data_d;
      miso_meta_q <= bus.i_miso;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign bus.o_csn     = csn_q;
  assign bus.o_sck     = sck_q;
  assign bus.o_wr      = wr_q;
  assign bus.o_data    = data_q;
  assign bus.o_overrun = ovr_q;

endmodule

// File: tb/tb_pmic_sampler.sv
// Bench for pmic_sampler: table vectors, corner-case sequences and randomized streams vs. a frame-level model.
module tb_pmic_sampler;
  localparam int H      = 4;
  localparam int MINPER = 34 * H + 1;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic [19:0] interval = '0;
  logic        miso     = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  pmic_sampler_if bus();
  assign bus.i_miso = miso;

  pmic_sampler #(.CLKDIV(H), .LGINTV(20)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_interval (interval),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: new word latched on CS fall, next bit presented on every SCK fall.
  logic [15:0] adc_words [0:63];
  logic [5:0]  adc_rd   = '0;
  logic [15:0] adc_word = '0;
  always @(negedge bus.o_csn) begin
    adc_word = adc_words[adc_rd];
    adc_rd   = adc_rd + 6'd1;
  end
  always @(negedge bus.o_sck) begin
    if (bus.o_csn === 1'b0) begin
      miso     = adc_word[15];
      adc_word = adc_word << 1;
    end
  end

  // Cumulative pin-activity monitor, sampled mid-cycle.
  logic        p_sck = 1'b1, p_csn = 1'b1;
  int          n_fall = 0, n_rise = 0, n_idle_edge = 0, lo_run = 0, lo_bad = 0;
  int          n_csnfall = 0, csn_fall_cyc = 0, csn_rise_cyc = 0, n_wr = 0;
  int          wr_cyc_a [0:255];
  logic [11:0] wr_dat_a [0:255];
  always @(negedge clk) begin
    if (p_sck === 1'b1 && bus.o_sck === 1'b0) begin
      lo_run = 1;
      if (bus.o_csn === 1'b0) n_fall++; else n_idle_edge++;
    end else if (bus.o_sck === 1'b0) begin
      lo_run++;
    end
    if (p_sck === 1'b0 && bus.o_sck === 1'b1) begin
      if (bus.o_csn === 1'b0) begin
        n_rise++;
        if (lo_run != H) lo_bad++;
      end else begin
        n_idle_edge++;
      end
    end
    if (p_csn === 1'b1 && bus.o_csn === 1'b0) begin
      n_csnfall++;
      csn_fall_cyc = cyc;
    end
    if (p_csn === 1'b0 && bus.o_csn === 1'b1) csn_rise_cyc = cyc;
    if (bus.o_wr === 1'b1) begin
      wr_cyc_a[n_wr[7:0]] = cyc;
      wr_dat_a[n_wr[7:0]] = bus.o_data;
      n_wr++;
    end
    p_sck = bus.o_sck;
    p_csn = bus.o_csn;
  end

  typedef struct {
    logic [19:0] iv;
    logic [15:0] word;
    logic [11:0] exp_data;
    int          exp_per;
    bit          exp_ovr;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    en = 1'b0;
    #2 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic wait_wr(input int target, input int budget);
    int k;
    k = 0;
    while (n_wr < target && k < budget) begin
      tick(1);
      k++;
    end
    chk("wr_arrived", int'(n_wr >= target), 1);
  endtask

  // Frame-level reference: data is word[11:0], spacing is max(max(iv,1), 34H+1).
  task automatic stream(input logic [19:0] iv, input int n, input bit incr, input string tag);
    logic [15:0] w [0:15];
    int base, per, ivv;
    do_reset();
    for (int i = 0; i < n; i++) begin
      w[i] = incr ? 16'(16'h0100 + i) : 16'($urandom);
      adc_words[adc_rd + 6'(i)] = w[i];
    end
    ivv  = (iv == 0) ? 1 : int'(iv);
    per  = (ivv < MINPER) ? MINPER : ivv;
    base = n_wr;
    interval = iv;
    en = 1'b1;
    wait_wr(base + n, n * per + 200);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, int'(wr_dat_a[8'(base + i)]), int'(w[i][11:0]));
      if (i > 0) chk({tag, "_period"}, wr_cyc_a[8'(base + i)] - wr_cyc_a[8'(base + i - 1)], per);
    end
    chk({tag, "_overrun"}, int'(bus.o_overrun), int'(ivv < MINPER));
  endtask

  int base, s, f0, r0, b0, c0, e0, r;

  initial begin
    tbl[0] = '{20'd200, 16'h0A5C, 12'hA5C, 200, 1'b0};
    tbl[1] = '{20'd137, 16'h0123, 12'h123, 137, 1'b0};
    tbl[2] = '{20'd136, 16'h0FFF, 12'hFFF, 137, 1'b1};
    tbl[3] = '{20'd0,   16'hF123, 12'h123, 137, 1'b1};
    tbl[4] = '{20'd1,   16'h8001, 12'h001, 137, 1'b1};
    tbl[5] = '{20'd300, 16'h5000, 12'h000, 300, 1'b0};

    tick(2);
    chk("rst_csn", int'(bus.o_csn), 1);
    chk("rst_sck", int'(bus.o_sck), 1);
    chk("rst_wr", int'(bus.o_wr), 0);
    chk("rst_data", int'(bus.o_data), 0);
    chk("rst_overrun", int'(bus.o_overrun), 0);
    rst_n = 1'b1;
    tick(1);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int i = 0; i < 3; i++) adc_words[adc_rd + 6'(i)] = tbl[t].word;
      base = n_wr;
      interval = tbl[t].iv;
      en = 1'b1;
      wait_wr(base + 3, 3 * tbl[t].exp_per + 300);
      for (int i = 0; i < 3; i++) chk("tbl_data", int'(wr_dat_a[8'(base + i)]), int'(tbl[t].exp_data));
      for (int i = 1; i < 3; i++) chk("tbl_period", wr_cyc_a[8'(base + i)] - wr_cyc_a[8'(base + i - 1)], tbl[t].exp_per);
      chk("tbl_overrun", int'(bus.o_overrun), int'(tbl[t].exp_ovr));
    end

    // Single frame: pin timing in detail.
    do_reset();
    adc_words[adc_rd] = 16'h0A5C;
    f0 = n_fall; r0 = n_rise; b0 = lo_bad; base = n_wr;
    interval = 20'd200;
    en = 1'b1;
    s = cyc;
    wait_wr(base + 1, 400);
    chk("single_csn_fall", csn_fall_cyc - s, 1);
    chk("single_wr_time", wr_cyc_a[8'(base)] - s, 33 * H + 1);
    chk("single_csn_rise", csn_rise_cyc - s, 33 * H + 1);
    chk("single_data", int'(wr_dat_a[8'(base)]), 12'hA5C);
    chk("single_sck_falls", n_fall - f0, 16);
    chk("single_sck_rises", n_rise - r0, 16);
    chk("single_low_width", lo_bad - b0, 0);
    tick(10);
    chk("single_wr_once", n_wr - base, 1);

    // Overrun, then a one-clock enable drop clears it.
    stream(20'd136, 3, 1'b0, "ovr");
    en = 1'b0;
    tick(1);
    chk("ovr_clear", int'(bus.o_overrun), 0);
    en = 1'b1;
    tick(1);

    // Enable dropped mid-frame.
    do_reset();
    adc_words[adc_rd] = 16'h0321;
    c0 = n_csnfall; base = n_wr;
    interval = 20'd200;
    en = 1'b1;
    s = cyc;
    wait_until(s + 50);
    en = 1'b0;
    wait_wr(base + 1, 300);
    chk("dis_wr_time", wr_cyc_a[8'(base)] - s, 33 * H + 1);
    chk("dis_data", int'(wr_dat_a[8'(base)]), 12'h321);
    f0 = n_fall; e0 = n_idle_edge;
    tick(400);
    chk("dis_no_new_frame", n_csnfall - c0, 1);
    chk("dis_no_sck", (n_fall - f0) + (n_idle_edge - e0), 0);
    chk("dis_csn_high", int'(bus.o_csn), 1);
    chk("dis_no_wr", n_wr - base, 1);

    // Asynchronous reset in the middle of the second frame.
    do_reset();
    adc_words[adc_rd]        = 16'h0ABC;
    adc_words[adc_rd + 6'd1] = 16'h0111;
    adc_words[adc_rd + 6'd2] = 16'h0DEF;
    base = n_wr;
    interval = 20'd137;
    en = 1'b1;
    s = cyc;
    wait_wr(base + 1, 300);
    chk("arst_first_data", int'(wr_dat_a[8'(base)]), 12'hABC);
    wait_until(s + 137 + 60);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_csn", int'(bus.o_csn), 1);
    chk("arst_sck", int'(bus.o_sck), 1);
    chk("arst_wr", int'(bus.o_wr), 0);
    chk("arst_data", int'(bus.o_data), 0);
    base = n_wr;
    #1 rst_n = 1'b1;
    r = cyc;
    wait_wr(base + 1, 300);
    chk("arst_restart_csn", csn_fall_cyc - r, 1);
    chk("arst_restart_wr", wr_cyc_a[8'(base)] - r, 33 * H + 1);
    chk("arst_restart_data", int'(wr_dat_a[8'(base)]), 12'hDEF);

    // Periodic run and randomized intervals/words.
    stream(20'd137, 10, 1'b1, "periodic");
    for (int k = 0; k < 4; k++) stream(20'($urandom_range(0, 400)), 4, 1'b0, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
